// File: rtl/conversor_bcd_if.sv
// Start/finish handshake and data bus between the binary producer, the BCD
// converter and the display driver.
// Optional: CONVERSOR_BCD_BLANK_EN adds the leading-zero blanking mask.
interface conversor_bcd_if #(
  parameter int ANCHO_BIN   = 32,
  parameter int NUM_DIGITOS = 10
);
  logic                       iniciar;
  logic [ANCHO_BIN-1:0]       valor_bin;
  logic [4*NUM_DIGITOS-1:0]   bcd;
  logic                       terminado;
  logic                       ocupado;
  logic                       desbordamiento;
`ifdef CONVERSOR_BCD_BLANK_EN
  logic [NUM_DIGITOS-1:0]     mascara_digitos;

  modport master (
    output iniciar, valor_bin,
    input  bcd, terminado, ocupado, desbordamiento, mascara_digitos
  );
  modport slave (
    input  iniciar, valor_bin,
    output bcd, terminado, ocupado, desbordamiento, mascara_digitos
  );
`else
  modport master (
    output iniciar, valor_bin,
    input  bcd, terminado, ocupado, desbordamiento
  );
  modport slave (
    input  iniciar, valor_bin,
    output bcd, terminado, ocupado, desbordamiento
  );
`endif
endinterface

// File: rtl/conversor_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble), one input
// bit per clock. Result appears ANCHO_BIN edges after the accepting edge.
// Optional: define CONVERSOR_BCD_BLANK_EN to drive mascara_digitos, marking
// the digits at or below the most significant nonzero digit.
module conversor_bcd #(
  parameter int ANCHO_BIN   = 32,
  parameter int NUM_DIGITOS = 10
) (
  input logic            clk,
  input logic            rst_n,
  conversor_bcd_if.slave bus
);
  localparam int AC = (ANCHO_BIN > 1) ? $clog2(ANCHO_BIN) : 1;
  localparam int AB = 4 * NUM_DIGITOS;

  typedef enum logic {REPOSO, CONVIRTIENDO} estado_t;

  estado_t              estado, estado_sig;
  logic                 aceptar, fin;
  logic [ANCHO_BIN-1:0] desp, desp_sig;
  logic [AB-1:0]        trab, trab_corr, trab_sig;
  logic [AC-1:0]        contador;
  logic                 desb_flag, desb_sig;
  logic [AB-1:0]        bcd_q;
  logic                 terminado_q, ocupado_q, desb_q;

  // Add-3 correction on every working digit, applied before the shift so the
  // shifted digit never leaves the 0..9 range.
  for (genvar i = 0; i < NUM_DIGITOS; i++) begin : g_dig
    assign trab_corr[4*i +: 4] = (trab[4*i +: 4] >= 4'd5) ? trab[4*i +: 4] + 4'd3
                                                          : trab[4*i +: 4];
  end

  // One-bit left shift of {working BCD, shift register}; the bit leaving the
  // top digit is a lost 10^NUM_DIGITOS carry, hence the overflow flag.
  assign trab_sig = {trab_corr[AB-2:0], desp[ANCHO_BIN-1]};
  assign desp_sig = {desp[ANCHO_BIN-2:0], 1'b0};
  assign desb_sig = desb_flag | trab_corr[AB-1];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  // Next-state logic: start only accepted while idle, finish on the last bit.
  always_comb begin
    estado_sig = estado;
    aceptar    = 1'b0;
    fin        = 1'b0;
    case (estado)
      REPOSO: begin
        if (bus.iniciar) begin
          aceptar    = 1'b1;
          estado_sig = CONVIRTIENDO;
        end
      end
      CONVIRTIENDO: begin
        if (contador == AC'(ANCHO_BIN - 1)) begin
          fin        = 1'b1;
          estado_sig = REPOSO;
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

  // Datapath and registered handshake outputs; bcd only changes on finish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      desp        <= '0;
      trab        <= '0;
      contador    <= '0;
      desb_flag   <= 1'b0;
      bcd_q       <= '0;
      terminado_q <= 1'b0;
      ocupado_q   <= 1'b0;
      desb_q      <= 1'b0;
    end else if (aceptar) begin
      desp        <= bus.valor_bin;
      trab        <= '0;
      contador    <= '0;
      desb_flag   <= 1'b0;
      terminado_q <= 1'b0;
      ocupado_q   <= 1'b1;
      desb_q      <= 1'b0;
    end else if (estado == CONVIRTIENDO) begin
      desp      <= desp_sig;
      trab      <= trab_sig;
      contador  <= contador + 1'b1;
      desb_flag <= desb_sig;
      if (fin) begin
        bcd_q       <= trab_sig;
        terminado_q <= 1'b1;
        ocupado_q   <= 1'b0;
        desb_q      <= desb_sig;
      end
    end
  end

  assign bus.bcd            = bcd_q;
  assign bus.terminado      = terminado_q;
  assign bus.ocupado        = ocupado_q;
  assign bus.desbordamiento = desb_q;

`ifdef CONVERSOR_BCD_BLANK_EN
  logic [NUM_DIGITOS-1:0] mascara_q, mascara_sig;
  logic                   hay_digito;

  // Running OR from the top digit down: a digit is shown once any digit at or
  // above it is nonzero; the units digit is always shown.
  always_comb begin
    mascara_sig = '0;
    hay_digito  = 1'b0;
    for (int i = NUM_DIGITOS - 1; i >= 0; i--) begin
      hay_digito     = hay_digito | (|trab_sig[4*i +: 4]);
      mascara_sig[i] = hay_digito;
    end
    mascara_sig[0] = 1'b1;
  end

  // Mask register, updated together with bcd.
  always_ff @(posedge clk) begin
    if (!rst_n)   mascara_q <= NUM_DIGITOS'(1);
    else if (fin) mascara_q <= mascara_sig;
  end

  assign bus.mascara_digitos = mascara_q;
`endif
endmodule

// File: doc/conversor_bcd.md
Name: conversor_bcd

Overview:
- Sequential binary-to-BCD converter using the shift-add-3 (double dabble) algorithm, one bit per clock.
- Sits directly downstream of the 16x16 shift-add multiplier. It consumes the 32-bit `producto` when the multiplier raises `terminado`, and produces packed decimal digits for the display driver.
- Uses the same start/finish handshake as the multiplier, so the two chain with no glue logic.

Parameters:
- ANCHO_BIN, 32, width of the binary input.
- NUM_DIGITOS, 10, number of BCD output digits. 10 covers 2^32-1 = 4294967295.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- iniciar  input  1  start request; sampled only while idle
- valor_bin  input  ANCHO_BIN  unsigned binary value, latched on the accepting edge
- bcd  output  4*NUM_DIGITOS  packed result; digit 0 (units) in bits [3:0]
- terminado  output  1  result valid; sticky until the next accepted start
- ocupado  output  1  conversion in progress
- desbordamiento  output  1  value did not fit in NUM_DIGITOS digits; valid with terminado
- mascara_digitos  output  NUM_DIGITOS  present only with CONVERSOR_BCD_BLANK_EN (see below)

Behaviour:
- Reset, synchronous, when rst_n=0 at an edge:
  - Outputs: bcd=0, terminado=0, ocupado=0, desbordamiento=0, mascara_digitos=1 (units digit only).
  - Internals: shift register, working BCD register and bit counter cleared; FSM forced to REPOSO.
  - Reset mid-conversion aborts it immediately; no partial result is published.
- FSM states: REPOSO, CONVIRTIENDO.
- REPOSO, iniciar=1 at an edge:
  - Latch valor_bin into the shift register, clear the working BCD register, contador=0.
  - terminado<=0, desbordamiento<=0, ocupado<=1, go to CONVIRTIENDO.
  - bcd keeps its previous value until the new result is written.
- CONVIRTIENDO, each edge:
  - For every working digit >=5, add 3 (4-bit add).
  - Shift {working BCD, shift register} left by one bit; the shift register MSB enters digit 0 bit 0.
  - If bit 3 of the top digit is shifted out, set an internal overflow flag (sticky for this conversion).
  - contador increments.
- Finish edge (contador==ANCHO_BIN-1):
  - Write the post-shift working value to bcd.
  - terminado<=1, ocupado<=0, desbordamiento<=overflow flag, return to REPOSO.
- Latency: terminado goes high exactly ANCHO_BIN edges after the accepting edge (32 with defaults). Throughput is one conversion per ANCHO_BIN+1 cycles.
- iniciar while ocupado=1: ignored; no effect on the conversion or on latched data.
- iniciar=1 at the same edge terminado is already high (idle): accepted; terminado drops the next cycle.
- iniciar held high continuously: back-to-back conversions; each one re-samples valor_bin on its accepting edge.
- Width rule: the add-3 correction is applied before the shift, never after. Digit values in bcd are always 0..9, including when desbordamiento=1; in that case the low digits show the result modulo 10^NUM_DIGITOS.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: CONVERSOR_BCD_BLANK_EN.
- Defined:
  - Port mascara_digitos exists; it is updated on the finish edge together with bcd.
  - Bit i =1 when digit i is at or below the most significant nonzero digit.
  - Bit 0 is always 1, so a zero value shows "0".
  - The display driver blanks digits whose bit is 0.
- Not defined:
  - Port absent; no blanking logic is synthesized.
  - All other behaviour is identical.

Test Plan:
- Reset, then iniciar with valor_bin=0 -> after 32 cycles terminado=1, bcd=0, desbordamiento=0, mascara_digitos=10'b0000000001.
- valor_bin=65025 (multiplier output 255*255) -> bcd=0x0000065025, terminado exactly 32 edges after the accepting edge, ocupado high for those 32 cycles; mascara_digitos=10'b0000011111.
- valor_bin=32'hFFFFFFFF -> bcd=0x4294967295, desbordamiento=0, mascara_digitos all ones.
- Start with valor_bin=12345, then pulse iniciar with valor_bin=999 at cycle 10 -> second request ignored, result 0x0000012345. A later start with 999 after terminado gives 0x0000000999.
- Start a conversion, assert rst_n=0 at cycle 15 -> next cycle ocupado=0, terminado=0, bcd=0; no terminado pulse follows.
- NUM_DIGITOS=4, ANCHO_BIN=16, valor_bin=12345 -> terminado after 16 edges, desbordamiento=1, bcd=16'h2345.
